// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry hold buffer and the IF/ID pipeline register.
//
// state  | meaning
// FETCH  | imem_req high, waiting for the memory to accept the PC
// WAIT   | request accepted, waiting for imem_rvalid
// FULL   | response captured in the hold buffer, waiting for ID to accept it
// DRAIN  | a squashed request is outstanding; its response will be dropped
module if_fetch_stage #(
  parameter int                     ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]            NOP_INSTR  = 32'h00000013
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pc_load,
  input  logic                   if_id_load,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic                   fetch_busy
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic [31:0]           hold_instr;
  logic                  rsp_live;
  logic                  can_deliver;
  logic                  deliver;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] deliver_pc;
  logic [31:0]           deliver_instr;

  assign pc_plus4      = pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  assign rsp_live      = (state == S_WAIT) && imem_rvalid;
  assign can_deliver   = pc_load && if_id_load;
  // A redirect in the same cycle kills any delivery or capture.
  assign deliver       = !branch_taken && can_deliver &&
                         (rsp_live || (state == S_FULL));
  assign capture       = !branch_taken && rsp_live && !can_deliver;
  assign deliver_pc    = (state == S_FULL) ? hold_pc : pc;
  assign deliver_instr = (state == S_FULL) ? hold_instr : imem_rdata;

  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign fetch_busy = (state != S_FULL);

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (imem_ack) state_nx = branch_taken ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (branch_taken)     state_nx = imem_rvalid ? S_FETCH : S_DRAIN;
        else if (imem_rvalid) state_nx = can_deliver ? S_FETCH : S_FULL;
      end
      S_FULL: begin
        if (branch_taken || can_deliver) state_nx = S_FETCH;
      end
      default: begin
        if (imem_rvalid) state_nx = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      if (branch_taken) pc <= branch_target;
      else if (deliver) pc <= pc_plus4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else if (capture) begin
      hold_pc    <= pc;
      hold_instr <= imem_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (deliver) begin
      if_id_pc    <= deliver_pc;
      if_id_instr <= deliver_instr;
      if_id_valid <= 1'b1;
    end else if (if_id_load) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, checked
// against a transaction-level model (outstanding / squashed / held flags).
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_load = 1'b0;
  logic        if_id_load = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_busy;

  if_fetch_stage #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .pc_load(pc_load), .if_id_load(if_id_load),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // reference model: architectural view of the fetch stage
  logic [63:0] m_pc, m_ifid_pc, m_hold_pc;
  logic [31:0] m_ifid_instr, m_hold_instr;
  bit          m_ifid_valid, m_out, m_squash, m_held;

  // memory model
  bit          mem_pending = 0;
  int          mem_wait = 0;
  bit          rd_use = 0;
  logic [31:0] rd_fixed = '0;

  task automatic model_reset();
    m_pc = 64'h0; m_ifid_pc = 64'h0; m_ifid_instr = NOP; m_ifid_valid = 0;
    m_out = 0; m_squash = 0; m_held = 0; m_hold_pc = '0; m_hold_instr = NOP;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input bit in_reset);
    chk("imem_req",    {63'b0, imem_req},    {63'b0, !in_reset && !m_out && !m_held});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("if_id_pc",    if_id_pc,             m_ifid_pc);
    chk("if_id_instr", {32'b0, if_id_instr}, {32'b0, m_ifid_instr});
    chk("if_id_valid", {63'b0, if_id_valid}, {63'b0, m_ifid_valid});
    chk("fetch_busy",  {63'b0, fetch_busy},  {63'b0, !m_held});
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance model.
  task automatic step(input bit ack_i, input int lat_i, input bit br_i,
                      input logic [63:0] tgt_i, input bit pl_i, input bit il_i);
    bit rv, ack, br, req, resp, have, n_out;
    logic [31:0] rd, ins;
    @(negedge clock);
    check_all(0);
    rv = 0;
    rd = rd_use ? rd_fixed : $urandom;
    req = !m_out && !m_held;
    ack = ack_i && req && !mem_pending;
    if (mem_pending) begin
      if (mem_wait == 0) begin rv = 1; mem_pending = 0; end
      else mem_wait--;
    end
    br = br_i && !(m_out && m_squash && rv);
    imem_ack = ack; imem_rvalid = rv; imem_rdata = rd;
    branch_taken = br; branch_target = tgt_i;
    pc_load = pl_i; if_id_load = il_i;
    resp = m_out && rv;
    if (br) begin
      m_pc = tgt_i;
      m_ifid_instr = NOP; m_ifid_valid = 0;
      m_held = 0;
      n_out = (m_out && !rv) || ack;
      m_out = n_out; m_squash = n_out;
    end else begin
      have = m_held || (resp && !m_squash);
      ins = m_held ? m_hold_instr : rd;
      if (resp) begin m_out = 0; m_squash = 0; end
      if (have && pl_i && il_i) begin
        m_ifid_pc = m_pc; m_ifid_instr = ins; m_ifid_valid = 1;
        m_pc = m_pc + 64'd4;
        m_held = 0;
      end else begin
        if (have && !m_held) begin
          m_held = 1; m_hold_instr = rd; m_hold_pc = m_pc;
        end
        if (il_i) begin m_ifid_instr = NOP; m_ifid_valid = 0; end
      end
      if (ack) begin m_out = 1; m_squash = 0; end
    end
    if (ack) begin mem_pending = 1; mem_wait = lat_i; end
  endtask

  initial begin
    logic [63:0] tgt;
    model_reset();
    #12;
    check_all(1);
    @(negedge clock);
    reset = 1'b0;

    // first fetch, immediate ack, rvalid one cycle later, both loads high
    rd_use = 1; rd_fixed = 32'h00500093;
    step(1, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);

    // data hazard: loads low while the response arrives, then release
    rd_fixed = 32'h00a00113;
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);

    // redirect in WAIT two cycles before rvalid
    rd_fixed = 32'hdeadbeef;
    step(1, 2, 0, '0, 1, 1);
    step(0, 0, 1, 64'h100, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);

    // redirect coincident with ack, pc_load low
    step(1, 1, 1, 64'h200, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 1, 1);

    // slow memory: ack after 4 idle cycles, rvalid 5 cycles later
    rd_fixed = 32'h00108093;
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 1);
    step(1, 4, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);

    // PC wraps at the top of the address space
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    step(1, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);

    // async reset mid-WAIT; the late response must be ignored
    step(1, 2, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    imem_ack = 0; imem_rvalid = 0; branch_taken = 0;
    model_reset();
    #1;
    check_all(1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1, 1);

    // random traffic
    rd_use = 0;
    for (int i = 0; i < 600; i++) begin
      tgt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hC);
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    check_all(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
